riscv_regfile_mp: RTL and testbench
===================================

# riscv_regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the fixed 2-read/1-write file. Configurable register count, data width, read-port count and write-port count, with x0 hardwired to zero and a hardware clear sequencer that zeroes every register after reset. It sits between decode (read ports) and writeback (write ports). `rf_ready_o` tells the pipeline when the file holds valid architectural state.

## Interface
- `DATA_W`, 32: register width in bits.
- `NUM_REGS`, 32: number of registers; power of 2, at least 4. `AW = $clog2(NUM_REGS)`.
- `NUM_RD`, 2: read ports, 1..4.
- `NUM_WR`, 1: write ports, 1..2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `rf_wr_en_i`  in  NUM_WR: per-port write enable.
- `rf_wr_addr_i`  in  NUM_WR*AW: packed write addresses; port k uses bits [k*AW +: AW].
- `rf_wr_data_i`  in  NUM_WR*DATA_W: packed write data.
- `rf_rd_addr_i`  in  NUM_RD*AW: packed read addresses.
- `rf_rd_data_o`  out  NUM_RD*DATA_W: packed read data, combinational.
- `rf_ready_o`  out  1: high once the clear sequence is done.
- `rf_wr_collision_o`  out  1: registered one-cycle pulse when two enabled write ports target the same non-zero address.

## Operation
- FSM with two states, INIT and READY. `reset` forces INIT with `clr_ptr` = 1.
- INIT, reset low:
  - Each cycle writes 0 to `reg[clr_ptr]` and increments `clr_ptr`.
  - On the cycle that clears `NUM_REGS-1`, the next state is READY.
  - External writes are ignored. All read data is 0.
  - `rf_ready_o` = 0.
- READY:
  - Each enabled write port writes `reg[addr] <= data` at the rising edge.
  - Writes to address 0 are discarded.
- Write collision (NUM_WR=2, both enabled, same non-zero address):
  - Port 1 wins.
  - `rf_wr_collision_o` pulses the next cycle.
  - The collision is not flagged in INIT or for address 0.
- Reads:
  - Address 0 always returns 0.
  - Other addresses return `reg[addr]`, subject to the bypass rule in Configuration.
- x0 storage is never written. The implementation may omit it.
- Reset mid-operation:
  - Any cycle with `reset` high returns the FSM to INIT with `clr_ptr` = 1.
  - The whole clear restarts, including after a partial clear.
  - Register contents are not otherwise preserved.

## Timing
- Reset values: `rf_ready_o` = 0, `rf_wr_collision_o` = 0, `rf_rd_data_o` = 0 (INIT forces zero reads).
- Clear latency:
  - Counting from the first rising edge with `reset` low as edge 1, `reg[k]` is cleared at edge k.
  - `rf_ready_o` rises after edge `NUM_REGS-1`. With 32 registers that is edge 31.
- Write-to-read latency:
  - 0 cycles with bypass.
  - 1 cycle without bypass: new data is visible the cycle after the write edge.
- The read path is purely combinational from `rf_rd_addr_i` to `rf_rd_data_o`. No read enable, no handshake.
- `rf_wr_collision_o` is high for exactly one cycle, the cycle after the colliding write edge.

## Configuration
- Macro `RF_BYPASS_EN`.
- Defined:
  - A read of address A returns the incoming write data when a write port is enabled to A ≠ 0 in the same cycle in READY.
  - With two matching ports, port 1's data is returned.
- Undefined:
  - Reads return the stored value only.
  - A same-cycle write becomes visible after the edge.
- The macro does not change x0 or INIT behaviour: reads are still 0.

## Test plan
- Clear sequence:
  - Stimulus: preload x5=0xDEADBEEF, assert `reset` for 1 cycle, release.
  - Required: `rf_ready_o` stays 0 through edge 30 and is 1 after edge 31.
  - Required: reading x5 after ready returns 0.
  - Required: writes issued during INIT have no effect.
- x0 hardwire:
  - Stimulus: write 0x12345678 to x0.
  - Required: all read ports addressing x0 return 0, both same-cycle and later.
- Bypass:
  - Stimulus: write x7=0xA5A5A5A5 and read x7 on port 0 in the same cycle.
  - Required with `RF_BYPASS_EN`: 0xA5A5A5A5 that cycle.
  - Required without it: the old value that cycle and 0xA5A5A5A5 the next.
- Collision (NUM_WR=2):
  - Stimulus: port 0 writes x3=0x1111, port 1 writes x3=0x2222.
  - Required: x3 reads 0x2222.
  - Required: `rf_wr_collision_o` is high for exactly one cycle, the cycle after the write edge.
  - Required: the same collision on x0 raises no flag.
- Mid-clear reset:
  - Stimulus: assert `reset` at edge 10 of INIT.
  - Required: clear restarts at x1, and `rf_ready_o` rises 31 edges after the release.
- Multi-port read (NUM_RD=4):
  - Stimulus: load xN=N*0x01010101, then read x1, x2, x30, x31 simultaneously.
  - Required: each port returns its own register's value.

Source files
------------

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a post-reset clear sequencer.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module riscv_regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_WR-1:0]                    rf_wr_en_i,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]   rf_wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]             rf_wr_data_i,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   rf_rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]             rf_rd_data_o,
    output logic                                 rf_ready_o,
    output logic                                 rf_wr_collision_o
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic {INIT, READY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic              coll_d, coll_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [AW-1:0]     rd_a;
    logic [DATA_W-1:0] rd_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clr_ptr_q <= AW'(1);
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            coll_q    <= coll_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(NUM_REGS - 1)) begin
                state_d = READY;
            end
        end
    end

    // Later write ports take precedence, so port 1 wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                regs[clr_ptr_q] <= '0;
            end else begin
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (rf_wr_en_i[k] && (rf_wr_addr_i[k*AW +: AW] != '0)) begin
                        regs[rf_wr_addr_i[k*AW +: AW]] <= rf_wr_data_i[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    generate
        if (NUM_WR > 1) begin : g_coll
            assign coll_d = (state_q == READY) && rf_wr_en_i[0] && rf_wr_en_i[1] &&
                            (rf_wr_addr_i[0 +: AW] == rf_wr_addr_i[AW +: AW]) &&
                            (rf_wr_addr_i[0 +: AW] != '0);
        end else begin : g_no_coll
            assign coll_d = 1'b0;
        end
    endgenerate

    always_comb begin
        rf_rd_data_o = '0;
        rd_a         = '0;
        rd_v         = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_a = rf_rd_addr_i[p*AW +: AW];
            rd_v = '0;
            if ((state_q == READY) && (rd_a != '0)) begin
                rd_v = regs[rd_a];
`ifdef RF_BYPASS_EN
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (!reset && rf_wr_en_i[k] && (rf_wr_addr_i[k*AW +: AW] == rd_a)) begin
                        rd_v = rf_wr_data_i[k*DATA_W +: DATA_W];
                    end
                end
`endif
            end
            rf_rd_data_o[p*DATA_W +: DATA_W] = rd_v;
        end
    end

    assign rf_ready_o        = (state_q == READY);
    assign rf_wr_collision_o = coll_q;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed self-checking bench for riscv_regfile_mp with 4 read ports and 2 write ports.
module tb_riscv_regfile_mp;
    logic         clk;
    logic         reset;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic         ready;
    logic         coll;

    int total;
    int bad;

    riscv_regfile_mp #(
        .DATA_W(32),
        .NUM_REGS(32),
        .NUM_RD(4),
        .NUM_WR(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rf_wr_en_i(wr_en),
        .rf_wr_addr_i(wr_addr),
        .rf_wr_data_i(wr_data),
        .rf_rd_addr_i(rd_addr),
        .rf_rd_data_o(rd_data),
        .rf_ready_o(ready),
        .rf_wr_collision_o(coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic idle();
        set_wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_addr = {a3, a2, a1, a0};
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        idle();
        set_rd(5'd1, 5'd2, 5'd3, 5'd4);
        tick();
        tick();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        total++;
        if (coll !== 1'b0) begin bad++; $display("FAIL reset_coll: got %b expected 0", coll); end
        total++;
        if (rd_data !== 128'h0) begin bad++; $display("FAIL reset_rd: got %h expected 0", rd_data); end
        reset = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 31) begin bad++; $display("FAIL reset_clear_len: got %0d edges expected 31", n); end
    endtask

    task automatic test_clear();
        idle();
        set_wr(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        tick();
        idle();
        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        total++;
        if (rd_data[31:0] !== 32'hDEADBEEF)
            begin bad++; $display("FAIL preload_x5: got %h expected deadbeef", rd_data[31:0]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e >= 10 && e <= 20) set_wr(2'b11, 5'd5, 5'd6, 32'hFFFF0000, 32'h0000FFFF);
            else idle();
            tick();
            if (e == 2) begin
                total++;
                if (rd_data[31:0] !== 32'h0)
                    begin bad++; $display("FAIL init_read_zero: got %h expected 0", rd_data[31:0]); end
            end
            total++;
            if (ready !== 1'b0) begin bad++; $display("FAIL clear_ready_early edge %0d: got %b expected 0", e, ready); end
        end
        idle();
        tick();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL clear_ready_edge31: got %b expected 1", ready); end
        set_rd(5'd5, 5'd6, 5'd0, 5'd0);
        total++;
        if (rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL clear_x5: got %h expected 0", rd_data[31:0]); end
        total++;
        if (rd_data[63:32] !== 32'h0) begin bad++; $display("FAIL init_write_x6: got %h expected 0", rd_data[63:32]); end
    endtask

    task automatic test_x0();
        set_wr(2'b01, 5'd0, 5'd0, 32'h12345678, 32'h0);
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        total++;
        if (rd_data !== 128'h0) begin bad++; $display("FAIL x0_same_cycle: got %h expected 0", rd_data); end
        tick();
        idle();
        #1;
        total++;
        if (rd_data !== 128'h0) begin bad++; $display("FAIL x0_later: got %h expected 0", rd_data); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
        set_wr(2'b01, 5'd7, 5'd0, 32'h0BADF00D, 32'h0);
        tick();
        set_wr(2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0);
        set_rd(5'd7, 5'd0, 5'd0, 5'd0);
`ifdef RF_BYPASS_EN
        exp_now = 32'hA5A5A5A5;
`else
        exp_now = 32'h0BADF00D;
`endif
        total++;
        if (rd_data[31:0] !== exp_now)
            begin bad++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[31:0], exp_now); end
        tick();
        idle();
        #1;
        total++;
        if (rd_data[31:0] !== 32'hA5A5A5A5)
            begin bad++; $display("FAIL bypass_next_cycle: got %h expected a5a5a5a5", rd_data[31:0]); end
    endtask

    task automatic test_collision();
        set_wr(2'b11, 5'd3, 5'd3, 32'h00001111, 32'h00002222);
        set_rd(5'd3, 5'd0, 5'd0, 5'd0);
        total++;
        if (coll !== 1'b0) begin bad++; $display("FAIL coll_before_edge: got %b expected 0", coll); end
        tick();
        idle();
        #1;
        total++;
        if (coll !== 1'b1) begin bad++; $display("FAIL coll_pulse: got %b expected 1", coll); end
        total++;
        if (rd_data[31:0] !== 32'h00002222)
            begin bad++; $display("FAIL coll_winner: got %h expected 00002222", rd_data[31:0]); end
        tick();
        total++;
        if (coll !== 1'b0) begin bad++; $display("FAIL coll_one_cycle: got %b expected 0", coll); end
        set_wr(2'b11, 5'd0, 5'd0, 32'h00001111, 32'h00002222);
        tick();
        idle();
        total++;
        if (coll !== 1'b0) begin bad++; $display("FAIL coll_x0: got %b expected 0", coll); end
        set_wr(2'b11, 5'd8, 5'd9, 32'h00000008, 32'h00000009);
        tick();
        idle();
        total++;
        if (coll !== 1'b0) begin bad++; $display("FAIL coll_distinct: got %b expected 0", coll); end
    endtask

    task automatic test_mid_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            total++;
            if (ready !== 1'b0) begin bad++; $display("FAIL midreset_ready_early edge %0d: got %b expected 0", e, ready); end
        end
        tick();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready_edge31: got %b expected 1", ready); end
    endtask

    task automatic test_multi_read();
        for (int n = 1; n <= 31; n += 2) begin
            if (n < 31) set_wr(2'b11, 5'(n), 5'(n + 1), n * 32'h01010101, (n + 1) * 32'h01010101);
            else set_wr(2'b01, 5'(n), 5'd0, n * 32'h01010101, 32'h0);
            tick();
        end
        idle();
        set_rd(5'd1, 5'd2, 5'd30, 5'd31);
        total++;
        if (rd_data !== {32'h1F1F1F1F, 32'h1E1E1E1E, 32'h02020202, 32'h01010101})
            begin bad++; $display("FAIL multi_read_a: got %h expected 1f1f1f1f1e1e1e1e0202020201010101", rd_data); end
        set_rd(5'd31, 5'd30, 5'd2, 5'd1);
        total++;
        if (rd_data !== {32'h01010101, 32'h02020202, 32'h1E1E1E1E, 32'h1F1F1F1F})
            begin bad++; $display("FAIL multi_read_b: got %h expected 01010101020202021e1e1e1e1f1f1f1f", rd_data); end
        set_rd(5'd16, 5'd0, 5'd15, 5'd17);
        total++;
        if (rd_data !== {32'h11111111, 32'h0F0F0F0F, 32'h00000000, 32'h10101010})
            begin bad++; $display("FAIL multi_read_c: got %h expected 111111110f0f0f0f0000000010101010", rd_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        rd_addr = '0;
        test_reset();
        test_clear();
        test_x0();
        test_bypass();
        test_collision();
        test_mid_reset();
        test_multi_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
